// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Execution-stage ALU. MOVI/MOV/ADD/SUB complete on the edge that
//            accepts start. MULT (shift-add) and DIV (restoring) retire one
//            bit per cycle. A start/busy/done handshake lets the pipeline
//            stall while they run.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start_i            - launch request, sampled only while idle
//            alu_control_i[3:0] - operation code
//            a_i, b_i           - operands
//            result_o           - result / product low half / quotient
//            result_hi_o        - product high half / remainder / 0
//            zero_o             - result_o == 0
//            busy_o             - FSM not idle
//            done_o             - one-cycle completion pulse
//            div_by_zero_o      - DIV issued with b == 0
//            invalid_op_o       - undefined operation code issued
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       alu_control_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic             invalid_op_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] C_OP_MOVI = 4'b0000;
  localparam logic [3:0] C_OP_MOV  = 4'b0001;
  localparam logic [3:0] C_OP_ADD  = 4'b0010;
  localparam logic [3:0] C_OP_SUB  = 4'b0110;
  localparam logic [3:0] C_OP_MULT = 4'b1000;
  localparam logic [3:0] C_OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hi_q;      // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q;      // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] opnd_q;    // multiplicand / divisor
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             zero_q;
  logic             done_q;
  logic             div_by_zero_q;
  logic             invalid_op_q;

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole {carry, hi, lo} right by one. The consumed
  // multiplier bit falls off the bottom while product bits enter at the top.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;
  assign mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
  assign mul_hi_d = mul_sum[WIDTH:1];
  assign mul_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Restoring-division step: shift the next dividend bit into the remainder
  // and trial-subtract. Bit WIDTH of the difference is the borrow, because
  // the shifted remainder is always below 2*divisor.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;
  assign div_sh    = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_sh - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_rem_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_quo_d = {lo_q[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      result_hi_q   <= '0;
      zero_q        <= 1'b1;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      invalid_op_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            div_by_zero_q <= 1'b0;
            invalid_op_q  <= 1'b0;
            case (alu_control_i)
              C_OP_MOVI: begin
                result_q    <= b_i;
                result_hi_q <= '0;
                zero_q      <= (b_i == '0);
                done_q      <= 1'b1;
                state_q     <= S_DONE;
              end
              C_OP_MOV: begin
                result_q    <= a_i;
                result_hi_q <= '0;
                zero_q      <= (a_i == '0);
                done_q      <= 1'b1;
                state_q     <= S_DONE;
              end
              C_OP_ADD: begin
                result_q    <= a_i + b_i;
                result_hi_q <= '0;
                zero_q      <= ((a_i + b_i) == '0);
                done_q      <= 1'b1;
                state_q     <= S_DONE;
              end
              C_OP_SUB: begin
                result_q    <= a_i - b_i;
                result_hi_q <= '0;
                zero_q      <= (a_i == b_i);
                done_q      <= 1'b1;
                state_q     <= S_DONE;
              end
              C_OP_MULT: begin
                hi_q    <= '0;
                lo_q    <= b_i;
                opnd_q  <= a_i;
                cnt_q   <= CW'(WIDTH);
                state_q <= S_MUL;
              end
              C_OP_DIV: begin
                if (b_i == '0) begin
                  result_q      <= '1;
                  result_hi_q   <= a_i;
                  zero_q        <= 1'b0;
                  div_by_zero_q <= 1'b1;
                  done_q        <= 1'b1;
                  state_q       <= S_DONE;
                end else begin
                  hi_q    <= '0;
                  lo_q    <= a_i;
                  opnd_q  <= b_i;
                  cnt_q   <= CW'(WIDTH);
                  state_q <= S_DIV;
                end
              end
              default: begin
                result_q     <= '0;
                result_hi_q  <= '0;
                zero_q       <= 1'b1;
                invalid_op_q <= 1'b1;
                done_q       <= 1'b1;
                state_q      <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          hi_q  <= mul_hi_d;
          lo_q  <= mul_lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= mul_lo_d;
            result_hi_q <= mul_hi_d;
            zero_q      <= (mul_lo_d == '0);
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DIV: begin
          hi_q  <= div_rem_d;
          lo_q  <= div_quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= div_quo_d;
            result_hi_q <= div_rem_d;
            zero_q      <= (div_quo_d == '0);
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign result_o      = result_q;
  assign result_hi_o   = result_hi_q;
  assign zero_o        = zero_q;
  assign done_o        = done_q;
  assign div_by_zero_o = div_by_zero_q;
  assign invalid_op_o  = invalid_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Self-checking bench for alu_multicycle (WIDTH = 32). Expected
//            results are queued when an operation is launched and compared
//            by a monitor whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   alu_control_i = 4'h0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] result_o;
  logic [W-1:0] result_hi_o;
  logic         zero_o;
  logic         busy_o;
  logic         done_o;
  logic         div_by_zero_o;
  logic         invalid_op_o;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .alu_control_i (alu_control_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .result_o      (result_o),
    .result_hi_o   (result_hi_o),
    .zero_o        (zero_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .invalid_op_o  (invalid_op_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
    logic         inv;
  } exp_t;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
    logic         inv;
    int           lat;
    logic         tog;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model, written from the arithmetic definitions.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e.hi = '0; e.dbz = 1'b0; e.inv = 1'b0; e.res = '0;
    case (c)
      4'b0000: e.res = b;
      4'b0001: e.res = a;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b1000: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
      end
      4'b1001: begin
        if (b == '0) begin
          e.res = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b;
        end
      end
      default: e.inv = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = sb.pop_front();
          chk("result",      64'(result_o),      64'(e.res));
          chk("result_hi",   64'(result_hi_o),   64'(e.hi));
          chk("zero",        64'(zero_o),        64'(e.zero));
          chk("div_by_zero", 64'(div_by_zero_o), 64'(e.dbz));
          chk("invalid_op",  64'(invalid_op_o),  64'(e.inv));
        end
      end
    end
  end

  // Launch one operation, measure latency, and check busy release.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input int lat, input logic tog);
    int n;
    @(negedge clk);
    sb.push_back(e);
    start_i = 1'b1; alu_control_i = c; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    n = 1;
    while (!done_o && n < 100) begin
      if (tog) begin
        start_i = ~start_i;
        alu_control_i = 4'b0010;
        a_i = $urandom; b_i = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    chk("latency", 64'(n), 64'(lat));
    chk("busy_in_done", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    chk("busy_release", 64'(busy_o), 64'd0);
    chk("done_single_pulse", 64'(done_o), 64'd0);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [W-1:0] h, input logic z,
                              input logic d, input logic i, input int l, input logic t);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.res = r; v.hi = h; v.zero = z;
    v.dbz = d; v.inv = i; v.lat = l; v.tog = t;
    return v;
  endfunction

  initial begin
    vec_t vecs[15];
    exp_t e;
    logic [3:0] ops[6];
    logic [3:0] c;
    logic [W-1:0] ra, rb;

    vecs[0]  = mk(4'b0010, 32'd5,        32'd7,        32'd12,       32'd0,        1'b0, 1'b0, 1'b0, 1,  1'b0);
    vecs[1]  = mk(4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 32'd0,        1'b0, 1'b0, 1'b0, 1,  1'b0);
    vecs[2]  = mk(4'b0110, 32'd9,        32'd9,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1,  1'b0);
    vecs[3]  = mk(4'b0000, 32'hFFFF,     32'h1234,     32'h1234,     32'd0,        1'b0, 1'b0, 1'b0, 1,  1'b0);
    vecs[4]  = mk(4'b0001, 32'hDEAD,     32'h55,       32'hDEAD,     32'd0,        1'b0, 1'b0, 1'b0, 1,  1'b0);
    vecs[5]  = mk(4'b1000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1,        1'b0, 1'b0, 1'b0, 33, 1'b1);
    vecs[6]  = mk(4'b1001, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33, 1'b0);
    vecs[7]  = mk(4'b1001, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b1, 1'b0, 1,  1'b0);
    vecs[8]  = mk(4'b1111, 32'd8,        32'd9,        32'd0,        32'd0,        1'b1, 1'b0, 1'b1, 1,  1'b0);
    vecs[9]  = mk(4'b0011, 32'd8,        32'd9,        32'd0,        32'd0,        1'b1, 1'b0, 1'b1, 1,  1'b0);
    vecs[10] = mk(4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1,  1'b0);
    vecs[11] = mk(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33, 1'b0);
    vecs[12] = mk(4'b1001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0, 33, 1'b0);
    vecs[13] = mk(4'b1001, 32'd3,        32'd10,       32'd0,        32'd3,        1'b1, 1'b0, 1'b0, 33, 1'b0);
    vecs[14] = mk(4'b1000, 32'd0,        32'h12345,    32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 33, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result",    64'(result_o),      64'd0);
    chk("rst_result_hi", 64'(result_hi_o),   64'd0);
    chk("rst_zero",      64'(zero_o),        64'd1);
    chk("rst_busy",      64'(busy_o),        64'd0);
    chk("rst_done",      64'(done_o),        64'd0);
    chk("rst_dbz",       64'(div_by_zero_o), 64'd0);
    chk("rst_inv",       64'(invalid_op_o),  64'd0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      e.res = vecs[i].res; e.hi = vecs[i].hi; e.zero = vecs[i].zero;
      e.dbz = vecs[i].dbz; e.inv = vecs[i].inv;
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, e, vecs[i].lat, vecs[i].tog);
    end

    // Outputs hold after completion
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result",    64'(result_o),    64'd0);
    chk("hold_result_hi", 64'(result_hi_o), 64'd0);
    chk("hold_zero",      64'(zero_o),      64'd1);

    // Random operations checked against the model
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b1000; ops[5] = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      c  = ops[$urandom_range(5, 0)];
      ra = $urandom;
      rb = (c == 4'b1001) ? W'($urandom_range(5000, 0)) : W'($urandom);
      do_op(c, ra, rb, model(c, ra, rb),
            ((c == 4'b1000) || (c == 4'b1001 && rb != '0)) ? 33 : 1, 1'b0);
    end

    // Reset aborts an in-flight MULT with no done pulse
    @(negedge clk);
    start_i = 1'b1; alu_control_i = 4'b1000; a_i = 32'd1234; b_i = 32'd5678;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",   64'(busy_o),   64'd0);
    chk("abort_result", 64'(result_o), 64'd0);
    chk("abort_done",   64'(done_o),   64'd0);
    chk("abort_zero",   64'(zero_o),   64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_idle", 64'(busy_o), 64'd0);

    e = model(4'b0010, 32'd1, 32'd1);
    do_op(4'b0010, 32'd1, 32'd1, e, 1, 1'b0);
    chk("after_abort_add", 64'(result_o), 64'd2);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution-stage ALU directly downstream of the ALU control decoder; consumes its 4-bit alu_control code plus two operands.
- Single-cycle ops: MOVI, MOV, ADD, SUB.
- Iterative ops: MULT (shift-add, one bit per cycle) and DIV (restoring, one bit per cycle), sequenced by an internal FSM with a start/busy/done handshake so the datapath can stall.

Parameters:
- WIDTH, 32, operand/result width in bits (WIDTH >= 4).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to launch an operation; sampled only when busy=0.
- alu_control  input  4  operation code from ALU control: 0000 MOVI, 0001 MOV, 0010 ADD, 0110 SUB, 1000 MULT, 1001 DIV; every other code (incl. 1111) is invalid.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt, or sign-extended immediate for MOVI).
- result  output  WIDTH  primary result (MULT: low half of product; DIV: quotient).
- result_hi  output  WIDTH  MULT: high half of product; DIV: remainder; 0 for all other ops.
- zero  output  1  result == 0, registered together with result.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse; result, result_hi and flags are valid from this cycle on.
- div_by_zero  output  1  DIV issued with b == 0.
- invalid_op  output  1  undefined alu_control code issued.

Behaviour:
- Reset: the FSM goes to IDLE. result, result_hi, done, busy, div_by_zero and invalid_op are 0; zero is 1; the iteration counter is 0. Reset overrides start and aborts any in-flight MULT/DIV with no done pulse.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on start=1, capture alu_control, a and b.
  - Single-cycle ops: compute, register outputs and go to DONE on the same edge.
  - MULT: go to MUL. DIV with b != 0: go to DIV. Both load counter = WIDTH.
  - DIV with b == 0: result = all ones, result_hi = a, div_by_zero = 1, go to DONE.
  - Invalid code: result = 0, result_hi = 0, invalid_op = 1, go to DONE.
  - MUL/DIV: one iteration per edge, counter decrements. The edge that completes iteration WIDTH writes the outputs and goes to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- Latency, counting the start-sampling edge as edge 1: done is high after edge 1 for MOVI/MOV/ADD/SUB/invalid/div-by-zero, and after edge WIDTH+1 for MULT/DIV.
- Throughput: at most one operation every 2 cycles for single-cycle ops.
- Handshake:
  - busy = (state != IDLE), combinational from the state register.
  - start is ignored while busy=1, including in DONE. It is not queued.
  - Operands may change after the sampling edge without affecting the operation.
- Arithmetic, all unsigned, modulo 2^WIDTH where applicable:
  - MOVI: result = b.
  - MOV: result = a.
  - ADD: result = a + b, carry discarded.
  - SUB: result = a - b, borrow discarded.
  - MULT: {result_hi, result} = a * b, full 2*WIDTH-bit product.
  - DIV: result = a / b, result_hi = a % b.
- Flags:
  - div_by_zero and invalid_op are cleared at every new start acceptance and set only as above.
  - All outputs hold their last values until the next completion or reset.
  - zero is evaluated on result only.

Test Plan:
- Reset then ADD a=5, b=7 -> done one cycle after sampling; result=12, result_hi=0, zero=0, busy high for exactly 1 cycle.
- SUB a=3, b=5 -> result=0xFFFFFFFE. SUB a=9, b=9 -> result=0, zero=1. MOVI b=0x1234 -> result=0x1234. MOV a=0xDEAD -> result=0xDEAD.
- MULT a=0xFFFFFFFF, b=2 -> done exactly after edge 33; result=0xFFFFFFFE, result_hi=1. Toggle start and operands during busy -> no effect, single done pulse.
- DIV a=100, b=7 -> result=14, result_hi=2 after edge 33. DIV a=5, b=0 -> after edge 1: result=0xFFFFFFFF, result_hi=5, div_by_zero=1.
- alu_control=1111 and 0011 -> after edge 1: invalid_op=1, result=0, zero=1. Next valid ADD clears invalid_op.
- Assert rst on cycle 10 of a MULT -> next cycle is IDLE with busy=0 and result=0, no done pulse. A new ADD 1+1 then returns 2.
